rr_mux: RTL and testbench

RR_MUX -- requirements
Module: rr_mux

---
 rtl/rr_mux.sv | 78 +++++++
 tb/tb_rr_mux.sv | 124 ++++++++++++
 2 files changed

// File: rtl/rr_mux.sv
// rr_mux: NCH-channel valid/ready mux with fixed-select or round-robin arbitration
// into a single registered output stage.
module rr_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_ch;
    logic [SW-1:0]    r_ptr;
    logic             r_valid;
    logic             w_load;
    logic             w_sel_ok;
    logic             w_rr_hit;
    logic             w_grant;
    logic [SW-1:0]    w_rr_idx;
    logic [SW-1:0]    w_idx;
    logic [WIDTH-1:0] w_data;

    // (p + k) mod NCH, with p < NCH and k <= NCH so one subtraction suffices
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] p, input int k);
        logic [SW:0] s;
        s = {1'b0, p} + (SW+1)'(k);
        return (s >= (SW+1)'(NCH)) ? SW'(s - (SW+1)'(NCH)) : SW'(s);
    endfunction

    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!w_rr_hit && in_valid[wrap_add(r_ptr, k)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = wrap_add(r_ptr, k);
            end
        end
    end

    assign w_load   = !r_valid || out_ready;
    assign w_sel_ok = ({1'b0, sel} < (SW+1)'(NCH)) && in_valid[sel];
    assign w_idx    = mode ? w_rr_idx : sel;
    assign w_grant  = rst_n && w_load && (mode ? w_rr_hit : w_sel_ok);
    assign w_data   = in_data[w_idx*WIDTH +: WIDTH];
    assign in_ready = w_grant ? (NCH'(1) << w_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= SW'(NCH - 1);
        end else begin
            if (w_load)
                r_valid <= w_grant;
            if (w_grant) begin
                r_data <= w_data;
                r_ch   <= w_idx;
                if (mode)
                    r_ptr <= w_idx;
            end
        end
    end

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: directed stimulus with a scoreboard queue; a negedge monitor
// compares every word the DUT hands downstream against the queued expectation.
module tb_rr_mux;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  d [4];
    logic [33:0]  sb [$];
    int           n_chk = 0;
    int           n_pass = 0;

    assign in_data = {d[3], d[2], d[1], d[0]};

    rr_mux #(.WIDTH(32), .NCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // one cycle: drive, check in_ready before the edge, queue the expected word
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic ordy, input logic [3:0] exp_rdy,
                        input logic push, input logic [1:0] ech, input logic [31:0] edat);
        mode = m; sel = s; in_valid = v; out_ready = ordy;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (push) sb.push_back({ech, edat});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("out_data", 64'(out_data), 64'(sb[0][31:0]));
                chk("out_ch", 64'(out_ch), 64'(sb[0][33:32]));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'hA5A5A5A5; d[3] = 32'h33333333;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_ch", 64'(out_ch), 64'h0);

        for (int i = 0; i < 3; i++) step(1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA5A5A5A5);

        d[0] = 32'h00000000; d[1] = 32'h55555555; d[2] = 32'hAAAAAAAA; d[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (i % 4)), 1'b1, 2'(i % 4), d[i % 4]);

        step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h55555555);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hFFFFFFFF);
            else            step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h55555555);
        end

        d[0] = 32'hDDDDDDDD;
        step(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hDDDDDDDD);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0);
            chk("bp_valid", 64'(out_valid), 64'h1);
            chk("bp_data", 64'(out_data), 64'hDDDDDDDD);
        end
        d[0] = 32'h12345678;
        step(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h12345678);
        chk("bp_next_valid", 64'(out_valid), 64'h1);
        chk("bp_next_data", 64'(out_data), 64'h12345678);

        step(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);
        chk("idle_valid", 64'(out_valid), 64'h0);
        chk("idle_data", 64'(out_data), 64'h12345678);
        chk("idle_ch", 64'(out_ch), 64'h0);

        d[1] = 32'hCAFEF00D;
        step(1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hCAFEF00D);
        step(1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0);
        rst_n = 1'b0;
        step(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0);
        sb.delete();
        rst_n = 1'b1;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_data", 64'(out_data), 64'h0);
        chk("mid_rst_ch", 64'(out_ch), 64'h0);
        d[0] = 32'h0BADBEEF;
        step(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0BADBEEF);
        step(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);
        step(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
